// File: rtl/spi_device.sv
// spi_device: SPI target front end for single, dual and (optionally) quad IO.
// All pad inputs are resynchronised into the clk domain and the SPI clock is
// handled as an edge-detected strobe. Data is sampled on rising spi_clk and
// launched on falling spi_clk (clock idles high).
//
// Build option: define SPI_DEVICE_QUAD_EN to support spi_mode = 4. Without
// it, mode 4 is rejected like any other invalid mode and IO2/IO3 are never
// driven.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | chip select high (or not yet seen high since reset), no traffic
// ACTIVE | frame in progress: shifting rx on rising, tx on falling edges
module spi_device (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs_n,
    input  logic       spi_clk,
    input  logic [3:0] spi_data_in,
    output logic [3:0] spi_data_out,
    output logic [3:0] spi_data_oe,
    input  logic [2:0] spi_mode,
    input  logic       spi_dir,
    output logic [7:0] spi_byte_rx,
    output logic       spi_byte_rx_strobe,
    input  logic [7:0] spi_byte_tx,
    input  logic       spi_byte_tx_strobe,
    output logic       spi_byte_tx_req,
    output logic       spi_frame_start,
    output logic       spi_frame_end,
    output logic       spi_underrun
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state_q;
    logic [1:0] cs_sync_q;
    logic [1:0] clk_sync_q;
    logic [3:0] data_meta_q;
    logic [3:0] data_sync_q;
    logic       cs_prev_q;
    logic       clk_prev_q;
    logic [1:0] fill_q;
    logic       armed_q;
    logic [2:0] cnt_q;
    logic [7:0] rx_q;
    logic [7:0] tx_q;
    logic [7:0] hold_q;
    logic       hold_valid_q;
    logic       pend_q;
    logic       rose_q;
    logic [7:0] byte_rx_q;
    logic       rx_stb_q;
    logic       frame_start_q;
    logic       frame_end_q;
    logic       underrun_q;

    logic       cs_s;
    logic       cs_fall;
    logic       cs_rise;
    logic       clk_rise;
    logic       clk_fall;
    logic       mode_ok;
    logic [2:0] step_d;
    logic [2:0] cnt_d;
    logic [7:0] rx_d;
    logic [7:0] tx_shift_d;
    logic [7:0] load_byte_d;
    logic       load_under_d;
    logic       load_now;

    // Two-flop synchronizers plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_q   <= 2'b11;
            clk_sync_q  <= 2'b11;
            data_meta_q <= 4'h0;
            data_sync_q <= 4'h0;
            cs_prev_q   <= 1'b1;
            clk_prev_q  <= 1'b1;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            clk_sync_q  <= {clk_sync_q[0], spi_clk};
            data_meta_q <= spi_data_in;
            data_sync_q <= data_meta_q;
            cs_prev_q   <= cs_sync_q[1];
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    // The synchronizers reset to "CS high", so a pin already low at reset
    // would look like a falling edge. Arm only once a real high is observed.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
        end else if (fill_q != 2'd3) begin
            fill_q <= fill_q + 2'd1;
        end else if (cs_s) begin
            armed_q <= 1'b1;
        end
    end

    assign cs_s     = cs_sync_q[1];
    assign cs_fall  = cs_prev_q & ~cs_s & armed_q;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign clk_rise = ~clk_prev_q & clk_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_sync_q[1];

`ifdef SPI_DEVICE_QUAD_EN
    assign mode_ok = (spi_mode == 3'd1) || (spi_mode == 3'd2) || (spi_mode == 3'd4);
`else
    assign mode_ok = (spi_mode == 3'd1) || (spi_mode == 3'd2);
    logic unused_hi_data;
    assign unused_hi_data = ^data_sync_q[3:2];
`endif

    // Per-mode shift values and bit counter advance.
    always_comb begin
        step_d     = 3'd1;
        rx_d       = {rx_q[6:0], data_sync_q[0]};
        tx_shift_d = {tx_q[6:0], 1'b0};
        case (spi_mode)
            3'd2: begin
                step_d     = 3'd2;
                rx_d       = {rx_q[5:0], data_sync_q[1:0]};
                tx_shift_d = {tx_q[5:0], 2'b00};
            end
`ifdef SPI_DEVICE_QUAD_EN
            3'd4: begin
                step_d     = 3'd4;
                rx_d       = {rx_q[3:0], data_sync_q[3:0]};
                tx_shift_d = {tx_q[3:0], 4'h0};
            end
`endif
            default: ;
        endcase
        cnt_d = cnt_q + step_d;
    end

    // A strobe coinciding with a load goes straight to the shifter.
    assign load_byte_d  = spi_byte_tx_strobe ? spi_byte_tx :
                          (hold_valid_q ? hold_q : 8'hFF);
    assign load_under_d = ~spi_byte_tx_strobe & ~hold_valid_q;
    assign load_now     = ((state_q == IDLE) && cs_fall) ||
                          ((state_q == ACTIVE) && !cs_rise && mode_ok && clk_fall && pend_q);

    // Tx holding register and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else if (load_now) begin
            hold_valid_q <= 1'b0;
            if (load_under_d) underrun_q <= 1'b1;
        end else if (spi_byte_tx_strobe) begin
            hold_q       <= spi_byte_tx;
            hold_valid_q <= 1'b1;
        end
    end

    // Frame state machine with shift registers and registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            rx_q          <= 8'h00;
            tx_q          <= 8'h00;
            pend_q        <= 1'b0;
            rose_q        <= 1'b0;
            byte_rx_q     <= 8'h00;
            rx_stb_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            rx_stb_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q       <= ACTIVE;
                        cnt_q         <= 3'd0;
                        rx_q          <= 8'h00;
                        tx_q          <= load_byte_d;
                        pend_q        <= 1'b0;
                        rose_q        <= 1'b0;
                        frame_start_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        pend_q      <= 1'b0;
                        frame_end_q <= 1'b1;
                    end else if (mode_ok) begin
                        if (clk_rise) begin
                            rx_q   <= rx_d;
                            cnt_q  <= cnt_d;
                            rose_q <= 1'b1;
                            if (cnt_d == 3'd0) begin
                                byte_rx_q <= rx_d;
                                rx_stb_q  <= 1'b1;
                                pend_q    <= 1'b1;
                            end
                        end else if (clk_fall) begin
                            if (pend_q) begin
                                tx_q   <= load_byte_d;
                                pend_q <= 1'b0;
                                rose_q <= 1'b0;
                            end else if (rose_q) begin
                                tx_q <= tx_shift_d;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pad mapping: single drives IO1, dual IO1:IO0, quad IO3:IO0.
    always_comb begin
        spi_data_out = 4'h0;
        spi_data_oe  = 4'h0;
        if (state_q == ACTIVE && mode_ok) begin
            case (spi_mode)
                3'd1: begin
                    spi_data_out = {2'b00, tx_q[7], 1'b0};
                    spi_data_oe  = 4'b0010;
                end
                3'd2: begin
                    spi_data_out = {2'b00, tx_q[7:6]};
                    spi_data_oe  = 4'b0011;
                end
`ifdef SPI_DEVICE_QUAD_EN
                3'd4: begin
                    spi_data_out = tx_q[7:4];
                    spi_data_oe  = 4'b1111;
                end
`endif
                default: ;
            endcase
            if (!spi_dir) spi_data_oe = 4'h0;
        end
    end

    assign spi_byte_rx        = byte_rx_q;
    assign spi_byte_rx_strobe = rx_stb_q;
    assign spi_byte_tx_req    = ~hold_valid_q;
    assign spi_frame_start    = frame_start_q;
    assign spi_frame_end      = frame_end_q;
    assign spi_underrun       = underrun_q;

endmodule

// File: tb/tb_spi_device.sv
// Testbench for spi_device: a host-side model drives SPI frames and predicts
// the received bytes, the MISO groups and the output enables from the
// transferred byte lists.
module tb_spi_device;

    typedef logic [7:0] byteq_t [$];

    localparam int HALF = 8;
`ifdef SPI_DEVICE_QUAD_EN
    localparam bit QUAD = 1'b1;
`else
    localparam bit QUAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_cs_n = 1'b1;
    logic       spi_clk = 1'b1;
    logic [3:0] spi_data_in = 4'h0;
    logic [2:0] spi_mode = 3'd1;
    logic       spi_dir = 1'b1;
    logic [7:0] spi_byte_tx = 8'h00;
    logic       spi_byte_tx_strobe = 1'b0;
    logic [3:0] spi_data_out;
    logic [3:0] spi_data_oe;
    logic [7:0] spi_byte_rx;
    logic       spi_byte_rx_strobe;
    logic       spi_byte_tx_req;
    logic       spi_frame_start;
    logic       spi_frame_end;
    logic       spi_underrun;

    spi_device dut (
        .clk                (clk),
        .reset              (reset),
        .spi_cs_n           (spi_cs_n),
        .spi_clk            (spi_clk),
        .spi_data_in        (spi_data_in),
        .spi_data_out       (spi_data_out),
        .spi_data_oe        (spi_data_oe),
        .spi_mode           (spi_mode),
        .spi_dir            (spi_dir),
        .spi_byte_rx        (spi_byte_rx),
        .spi_byte_rx_strobe (spi_byte_rx_strobe),
        .spi_byte_tx        (spi_byte_tx),
        .spi_byte_tx_strobe (spi_byte_tx_strobe),
        .spi_byte_tx_req    (spi_byte_tx_req),
        .spi_frame_start    (spi_frame_start),
        .spi_frame_end      (spi_frame_end),
        .spi_underrun       (spi_underrun)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass = 0;
    int     rx_cnt = 0;
    int     fs_cnt = 0;
    int     fe_cnt = 0;
    bit     idle_chk = 1'b0;
    bit     exp_under = 1'b0;
    byteq_t txq;
    byteq_t exp_rx;
    byteq_t miso_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Compare process: received bytes, frame pulses and idle pad state.
    always @(negedge clk) begin
        if (spi_byte_rx_strobe) begin
            rx_cnt++;
            if (exp_rx.size() == 0) begin
                n_checks++;
                $display("FAIL rx_unexpected: got strobe with %0h expected none", spi_byte_rx);
            end else begin
                check("rx_byte", spi_byte_rx, exp_rx.pop_front());
            end
        end
        if (spi_frame_start) fs_cnt++;
        if (spi_frame_end) begin
            fe_cnt++;
            check("oe_at_frame_end", spi_data_oe, 4'h0);
        end
        if (idle_chk) begin
            check("idle_oe", spi_data_oe, 4'h0);
            check("idle_out", spi_data_out, 4'h0);
        end
    end

    // Host-side firmware: fill the tx holding register whenever it is empty.
    initial begin
        forever begin
            @(negedge clk);
            spi_byte_tx_strobe = 1'b0;
            if (!reset && spi_byte_tx_req && txq.size() > 0) begin
                spi_byte_tx        = txq.pop_front();
                spi_byte_tx_strobe = 1'b1;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        idle_chk = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_under = 1'b0;
        txq.delete();
        exp_rx.delete();
        miso_q.delete();
        repeat (8) @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check("rst_rx", spi_byte_rx, 8'h00);
        check("rst_rx_stb", spi_byte_rx_strobe, 1'b0);
        check("rst_out", spi_data_out, 4'h0);
        check("rst_oe", spi_data_oe, 4'h0);
        check("rst_tx_req", spi_byte_tx_req, 1'b1);
        check("rst_underrun", spi_underrun, 1'b0);
        check("rst_fs", spi_frame_start, 1'b0);
        check("rst_fe", spi_frame_end, 1'b0);
    endtask

    // One frame: rxd = bytes the host sends, txd = bytes firmware supplies.
    task automatic frame(input int mode, input bit dir, input byteq_t rxd,
                         input byteq_t txd, input int nbits, input bit raise);
        int         groups, loads, k, off, mask, capn;
        bit         valid;
        logic [7:0] cap, tb_byte;
        logic [3:0] grp, eo, eoe;
        valid  = (mode == 1) || (mode == 2) || (QUAD && mode == 4);
        mask   = (1 << mode) - 1;
        groups = nbits / mode;
        foreach (txd[i]) txq.push_back(txd[i]);
        if (valid) for (int i = 0; i < nbits / 8; i++) exp_rx.push_back(rxd[i]);
        loads = (valid && groups > 0) ? 1 + ((groups - 1) * mode) / 8 : 1;
        if (loads > txd.size()) exp_under = 1'b1;
        spi_mode = mode[2:0];
        spi_dir  = dir;
        idle_chk = 1'b0;
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        cap  = 8'h00;
        capn = 0;
        for (int g = 0; g < groups; g++) begin
            k   = (g * mode) / 8;
            off = (g * mode) % 8;
            spi_clk     = 1'b0;
            spi_data_in = 4'((rxd[k] >> (8 - mode - off)) & mask);
            repeat (HALF) @(negedge clk);
            tb_byte = (k < txd.size()) ? txd[k] : 8'hFF;
            grp = 4'((tb_byte >> (8 - mode - off)) & mask);
            eo  = !valid ? 4'h0 : (mode == 1) ? {grp[2:0], 1'b0} : grp;
            eoe = (!valid || !dir) ? 4'h0 : (mode == 1) ? 4'b0010 :
                  (mode == 2) ? 4'b0011 : 4'b1111;
            check("miso", spi_data_out, eo);
            check("oe", spi_data_oe, eoe);
            if (valid) begin
                if (mode == 1)      cap = {cap[6:0], spi_data_out[1]};
                else if (mode == 2) cap = {cap[5:0], spi_data_out[1:0]};
                else                cap = {cap[3:0], spi_data_out};
                capn += mode;
                if (capn == 8) begin
                    miso_q.push_back(cap);
                    capn = 0;
                end
            end
            spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        if (raise) begin
            spi_cs_n = 1'b1;
            repeat (6) @(negedge clk);
            idle_chk = 1'b1;
        end
    endtask

    int rx0, fs0, fe0;

    initial begin
        // Reset values.
        do_reset();
        check_reset_vals();
        idle_chk = 1'b1;

        // Single mode: rx 0xA5, MISO 0x3C.
        rx0 = rx_cnt; fs0 = fs_cnt; fe0 = fe_cnt;
        frame(1, 1'b1, '{8'hA5}, '{8'h3C}, 8, 1'b1);
        check("s1_rx_count", rx_cnt - rx0, 1);
        check("s1_rx_lit", spi_byte_rx, 8'hA5);
        check("s1_miso_n", miso_q.size(), 1);
        if (miso_q.size() > 0) check("s1_miso_lit", miso_q[0], 8'h3C);
        check("s1_fs", fs_cnt - fs0, 1);
        check("s1_fe", fe_cnt - fe0, 1);
        check("s1_underrun", spi_underrun, exp_under);
        check("s1_underrun_lit", spi_underrun, 1'b0);
        check("s1_rx_left", exp_rx.size(), 0);

        // Dual mode back-to-back: rx 0x12,0x34, MISO 0x9F,0x01.
        do_reset();
        idle_chk = 1'b1;
        rx0 = rx_cnt;
        frame(2, 1'b1, '{8'h12, 8'h34}, '{8'h9F, 8'h01}, 16, 1'b1);
        check("s2_rx_count", rx_cnt - rx0, 2);
        check("s2_rx_last_lit", spi_byte_rx, 8'h34);
        check("s2_miso_n", miso_q.size(), 2);
        if (miso_q.size() > 1) begin
            check("s2_miso0_lit", miso_q[0], 8'h9F);
            check("s2_miso1_lit", miso_q[1], 8'h01);
        end
        check("s2_underrun_lit", spi_underrun, 1'b0);

        // Quad request with nothing to send.
        do_reset();
        idle_chk = 1'b1;
        rx0 = rx_cnt;
        frame(4, 1'b1, '{8'hC3}, '{}, 8, 1'b1);
        check("s3_underrun", spi_underrun, exp_under);
        check("s3_underrun_lit", spi_underrun, 1'b1);
`ifdef SPI_DEVICE_QUAD_EN
        check("s3_rx_count", rx_cnt - rx0, 1);
        check("s3_rx_lit", spi_byte_rx, 8'hC3);
        if (miso_q.size() > 0) check("s3_miso_lit", miso_q[0], 8'hFF);
`else
        check("s3_rx_count", rx_cnt - rx0, 0);
        check("s3_rx_lit", spi_byte_rx, 8'h00);
`endif

        // CS aborted after 5 bits, then a clean frame.
        do_reset();
        idle_chk = 1'b1;
        rx0 = rx_cnt; fe0 = fe_cnt;
        frame(1, 1'b1, '{8'hB7}, '{}, 5, 1'b1);
        check("s4_rx_count", rx_cnt - rx0, 0);
        check("s4_fe", fe_cnt - fe0, 1);
        check("s4_underrun_lit", spi_underrun, 1'b1);
        frame(1, 1'b1, '{8'h81}, '{8'h5A}, 8, 1'b1);
        check("s4_rx_count2", rx_cnt - rx0, 1);
        check("s4_rx_lit", spi_byte_rx, 8'h81);
        if (miso_q.size() > 0) check("s4_miso_lit", miso_q[0], 8'h5A);
        check("s4_underrun_sticky", spi_underrun, exp_under);

        // Reset mid-byte with CS held low.
        do_reset();
        idle_chk = 1'b1;
        frame(1, 1'b1, '{8'hF0}, '{}, 3, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_under = 1'b0;
        txq.delete();
        exp_rx.delete();
        miso_q.delete();
        repeat (8) @(negedge clk);
        check_reset_vals();
        idle_chk = 1'b1;
        rx0 = rx_cnt; fs0 = fs_cnt;
        for (int i = 0; i < 8; i++) begin
            spi_clk = 1'b0;
            spi_data_in = 4'h1;
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        check("s5_no_strobe", rx_cnt - rx0, 0);
        check("s5_no_fs", fs_cnt - fs0, 0);
        check("s5_rx_lit", spi_byte_rx, 8'h00);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        frame(1, 1'b0, '{8'h66}, '{8'h99}, 8, 1'b1);
        check("s5_fs", fs_cnt - fs0, 1);
        check("s5_rx_count", rx_cnt - rx0, 1);
        check("s5_rx_lit2", spi_byte_rx, 8'h66);
        if (miso_q.size() > 0) check("s5_miso_lit", miso_q[0], 8'h99);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
